// File: rtl/npu_stream_loader.sv
// npu_stream_loader
//   Byte-stream (valid/ready) loader for the NPU parameter and image registers.
//   Fixed stream order: image, conv1 kernels, conv2 kernels (set-major, then
//   filter, then tap), FC weights, FC biases. When the last element lands,
//   start_npu pulses for one cycle and loaded stays high until the next load.
//   Optional feature macro: CHECKSUM_EN -- adds a trailing mod-256 checksum
//   element that must match the sum of all data elements before start_npu.
module npu_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_BYTES  = 784,
    parameter int K1_BYTES   = 96,
    parameter int K2_BYTES   = 48,
    parameter int FCW_BYTES  = 480,
    parameter int FCB_BYTES  = 10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_start,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [DATA_WIDTH*IMG_BYTES-1:0] image_flat,
    output logic [DATA_WIDTH*K1_BYTES-1:0]  kernel1_flat,
    output logic [DATA_WIDTH*K2_BYTES-1:0]  kernel2_flat,
    output logic [DATA_WIDTH*FCW_BYTES-1:0] fc_weight_flat,
    output logic [DATA_WIDTH*FCB_BYTES-1:0] fc_bias_flat,
    output logic                            start_npu,
    output logic                            busy,
    output logic                            loaded,
    output logic                            load_err
);

    localparam int CNT_W  = 10;
    localparam int IMG_AW = $clog2(IMG_BYTES);
    localparam int K1_AW  = $clog2(K1_BYTES);
    localparam int K2_AW  = $clog2(K2_BYTES);
    localparam int FCW_AW = $clog2(FCW_BYTES);
    localparam int FCB_AW = $clog2(FCB_BYTES);

    localparam logic [CNT_W-1:0] IMG_LAST = CNT_W'(IMG_BYTES - 1);
    localparam logic [CNT_W-1:0] K1_LAST  = CNT_W'(K1_BYTES - 1);
    localparam logic [CNT_W-1:0] K2_LAST  = CNT_W'(K2_BYTES - 1);
    localparam logic [CNT_W-1:0] FCW_LAST = CNT_W'(FCW_BYTES - 1);
    localparam logic [CNT_W-1:0] FCB_LAST = CNT_W'(FCB_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LOAD_IMG = 4'd1,
        LOAD_K1  = 4'd2,
        LOAD_K2  = 4'd3,
        LOAD_FCW = 4'd4,
        LOAD_FCB = 4'd5,
`ifdef CHECKSUM_EN
        CHK      = 4'd6,
`endif
        DONE     = 4'd7,
        LOADED   = 4'd8
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               loaded_q, loaded_d;
    logic               s_ready_q;
    logic               busy_q;
    logic               start_q;
    logic               accept_s;
    logic               we_img_s, we_k1_s, we_k2_s, we_fcw_s, we_fcb_s;

    logic [DATA_WIDTH-1:0] img_q [IMG_BYTES];
    logic [DATA_WIDTH-1:0] k1_q  [K1_BYTES];
    logic [DATA_WIDTH-1:0] k2_q  [K2_BYTES];
    logic [DATA_WIDTH-1:0] fcw_q [FCW_BYTES];
    logic [DATA_WIDTH-1:0] fcb_q [FCB_BYTES];

`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  err_q, err_d;
`endif

    // True for states in which the loader takes stream elements.
    function automatic logic in_stream(input state_t st);
        logic r;
        case (st)
            LOAD_IMG, LOAD_K1, LOAD_K2, LOAD_FCW, LOAD_FCB: r = 1'b1;
`ifdef CHECKSUM_EN
            CHK:                                            r = 1'b1;
`endif
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    assign accept_s = s_valid && s_ready_q;

    // Next-state, counter and region write-enable decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        we_img_s = 1'b0;
        we_k1_s  = 1'b0;
        we_k2_s  = 1'b0;
        we_fcw_s = 1'b0;
        we_fcb_s = 1'b0;
`ifdef CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
        // Running sum over data elements only; the checksum byte itself is excluded.
        if (accept_s && (state_q != CHK)) begin
            sum_d = sum_q + s_data;
        end else begin
            sum_d = sum_q;
        end
`endif
        case (state_q)
            IDLE, LOADED: begin
                if (load_start) begin
                    state_d  = LOAD_IMG;
                    cnt_d    = {CNT_W{1'b0}};
                    loaded_d = 1'b0;
`ifdef CHECKSUM_EN
                    err_d    = 1'b0;
                    sum_d    = {DATA_WIDTH{1'b0}};
`endif
                end else begin
                    state_d = state_q;
                end
            end
            LOAD_IMG: begin
                if (accept_s) begin
                    we_img_s = 1'b1;
                    if (cnt_q == IMG_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = LOAD_K1;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LOAD_K1: begin
                if (accept_s) begin
                    we_k1_s = 1'b1;
                    if (cnt_q == K1_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = LOAD_K2;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LOAD_K2: begin
                if (accept_s) begin
                    we_k2_s = 1'b1;
                    if (cnt_q == K2_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = LOAD_FCW;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LOAD_FCW: begin
                if (accept_s) begin
                    we_fcw_s = 1'b1;
                    if (cnt_q == FCW_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = LOAD_FCB;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LOAD_FCB: begin
                if (accept_s) begin
                    we_fcb_s = 1'b1;
                    if (cnt_q == FCB_LAST) begin
                        cnt_d   = {CNT_W{1'b0}};
`ifdef CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = DONE;
`endif
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                if (accept_s) begin
                    if (s_data == sum_q) begin
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = state_q;
                end
            end
`endif
            DONE: begin
                state_d  = LOADED;
                loaded_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            loaded_q  <= 1'b0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loaded_q  <= loaded_d;
            s_ready_q <= in_stream(state_d);
            busy_q    <= in_stream(state_d);
            start_q   <= (state_d == DONE);
        end
    end

`ifdef CHECKSUM_EN
    // Checksum accumulator and sticky mismatch flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= {DATA_WIDTH{1'b0}};
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    // Region storage; old contents survive until overwritten by a later load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IMG_BYTES; i++) img_q[i] <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < K1_BYTES;  i++) k1_q[i]  <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < K2_BYTES;  i++) k2_q[i]  <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < FCW_BYTES; i++) fcw_q[i] <= {DATA_WIDTH{1'b0}};
            for (int i = 0; i < FCB_BYTES; i++) fcb_q[i] <= {DATA_WIDTH{1'b0}};
        end else begin
            if (we_img_s) img_q[cnt_q[IMG_AW-1:0]] <= s_data;
            if (we_k1_s)  k1_q[cnt_q[K1_AW-1:0]]   <= s_data;
            if (we_k2_s)  k2_q[cnt_q[K2_AW-1:0]]   <= s_data;
            if (we_fcw_s) fcw_q[cnt_q[FCW_AW-1:0]] <= s_data;
            if (we_fcb_s) fcb_q[cnt_q[FCB_AW-1:0]] <= s_data;
        end
    end

    for (genvar g = 0; g < IMG_BYTES; g++) begin : g_img
        assign image_flat[g*DATA_WIDTH +: DATA_WIDTH] = img_q[g];
    end
    for (genvar g = 0; g < K1_BYTES; g++) begin : g_k1
        assign kernel1_flat[g*DATA_WIDTH +: DATA_WIDTH] = k1_q[g];
    end
    for (genvar g = 0; g < K2_BYTES; g++) begin : g_k2
        assign kernel2_flat[g*DATA_WIDTH +: DATA_WIDTH] = k2_q[g];
    end
    for (genvar g = 0; g < FCW_BYTES; g++) begin : g_fcw
        assign fc_weight_flat[g*DATA_WIDTH +: DATA_WIDTH] = fcw_q[g];
    end
    for (genvar g = 0; g < FCB_BYTES; g++) begin : g_fcb
        assign fc_bias_flat[g*DATA_WIDTH +: DATA_WIDTH] = fcb_q[g];
    end

    assign s_ready   = s_ready_q;
    assign busy      = busy_q;
    assign start_npu = start_q;
    assign loaded    = loaded_q;

endmodule

// File: tb/tb_npu_stream_loader.sv
// Directed testbench for npu_stream_loader.
//   Honours CHECKSUM_EN: when defined, every stream carries a trailing checksum.
module tb_npu_stream_loader;

    localparam int NDATA = 1418;
`ifdef CHECKSUM_EN
    localparam int TOTAL = NDATA + 1;
`else
    localparam int TOTAL = NDATA;
`endif
    localparam int GUARD = 10000;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [8*784-1:0]  image_flat;
    logic [8*96-1:0]   kernel1_flat;
    logic [8*48-1:0]   kernel2_flat;
    logic [8*480-1:0]  fc_weight_flat;
    logic [8*10-1:0]   fc_bias_flat;
    logic              start_npu;
    logic              busy;
    logic              loaded;
    logic              load_err;

    int n_tests  = 0;
    int n_failed = 0;
    int start_pulses = 0;

    npu_stream_loader dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .image_flat     (image_flat),
        .kernel1_flat   (kernel1_flat),
        .kernel2_flat   (kernel2_flat),
        .fc_weight_flat (fc_weight_flat),
        .fc_bias_flat   (fc_bias_flat),
        .start_npu      (start_npu),
        .busy           (busy),
        .loaded         (loaded),
        .load_err       (load_err)
    );

    always #5 clk = ~clk;

    // Count high cycles of start_npu, sampled mid-cycle.
    always @(negedge clk) begin
        if (start_npu) start_pulses <= start_pulses + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Data element i for pattern mode: 1 = all 0xFF, otherwise i mod 256.
    function automatic logic [7:0] data_elem(input int i, input int mode);
        logic [7:0] r;
        if (mode == 1) r = 8'hFF;
        else           r = 8'(i % 256);
        return r;
    endfunction

    // Stream element i; index NDATA is the checksum (mode 2 sends a bad one).
    function automatic logic [7:0] stream_elem(input int i, input int mode);
        logic [7:0] s;
        if (i < NDATA) return data_elem(i, mode);
        if (mode == 2) return 8'h00;
        s = 8'h00;
        for (int j = 0; j < NDATA; j++) s = s + data_elem(j, mode);
        return s;
    endfunction

    // Element i as seen on the flattened outputs, in stream order.
    function automatic logic [7:0] dut_elem(input int i);
        if (i < 784) return image_flat[i*8 +: 8];
        if (i < 880) return kernel1_flat[(i-784)*8 +: 8];
        if (i < 928) return kernel2_flat[(i-880)*8 +: 8];
        if (i < 1408) return fc_weight_flat[(i-928)*8 +: 8];
        return fc_bias_flat[(i-1408)*8 +: 8];
    endfunction

    task automatic pulse_load();
        load_start = 1'b1;
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    // Send n elements; returns at posedge+1 of the edge that took the last one.
    task automatic run_stream(input int n, input int mode, input bit toggle, input int pulse_at);
        int sent;
        int cyc;
        sent = 0;
        cyc  = 0;
        while (sent < n && cyc < GUARD) begin
            s_valid    = toggle ? (cyc % 2 == 0) : 1'b1;
            s_data     = stream_elem(sent, mode);
            load_start = (sent == pulse_at);
            @(negedge clk);
            if (s_valid && s_ready) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        s_valid    = 1'b0;
        load_start = 1'b0;
        if (sent < n) check_value("stream_timeout", 32'(sent), 32'(n));
    endtask

    // Start pulse must be up right after the last accept, for exactly one cycle.
    task automatic expect_done(input int pulses_before);
        check_value("start_after_last", 32'(start_npu), 32'd1);
        check_value("loaded_before_done", 32'(loaded), 32'd0);
        @(posedge clk); #1;
        check_value("start_one_cycle", 32'(start_npu), 32'd0);
        check_value("loaded_after_done", 32'(loaded), 32'd1);
        check_value("busy_after_done", 32'(busy), 32'd0);
        check_value("start_pulse_count", 32'(start_pulses - pulses_before), 32'd1);
        check_value("load_err_clear", 32'(load_err), 32'd0);
    endtask

    task automatic check_contents(input int mode);
        int errs;
        errs = 0;
        for (int i = 0; i < NDATA; i++) begin
            if (dut_elem(i) !== data_elem(i, mode)) errs++;
        end
        check_value("region_contents", 32'(errs), 32'd0);
    endtask

    int pb;

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_image", 32'(|image_flat), 32'd0);
        check_value("rst_fcw", 32'(|fc_weight_flat), 32'd0);
        check_value("rst_s_ready", 32'(s_ready), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_loaded", 32'(loaded), 32'd0);
        check_value("rst_start", 32'(start_npu), 32'd0);
        check_value("rst_err", 32'(load_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_value("idle_s_ready", 32'(s_ready), 32'd0);

        // Pattern i mod 256, continuous valid.
        pb = start_pulses;
        pulse_load();
        check_value("busy_on_start", 32'(busy), 32'd1);
        check_value("s_ready_on_start", 32'(s_ready), 32'd1);
        run_stream(TOTAL, 0, 1'b0, -1);
        expect_done(pb);
        check_contents(0);
        check_value("image0", 32'(dut_elem(0)), 32'h00);
        check_value("image783", 32'(dut_elem(783)), 32'h0F);
        check_value("kernel1_0", 32'(dut_elem(784)), 32'h10);
        check_value("kernel2_0", 32'(dut_elem(880)), 32'h70);
        check_value("fc_weight0", 32'(dut_elem(928)), 32'hA0);
        check_value("fc_bias9", 32'(dut_elem(1417)), 32'h89);
        repeat (3) @(posedge clk);
        #1;
        check_value("loaded_holds", 32'(loaded), 32'd1);

        // Reload from LOADED with all 0xFF.
        pb = start_pulses;
        pulse_load();
        check_value("loaded_drop", 32'(loaded), 32'd0);
        run_stream(TOTAL, 1, 1'b0, -1);
        expect_done(pb);
        check_contents(1);

        // Pattern again with valid toggling every cycle.
        pb = start_pulses;
        pulse_load();
        run_stream(TOTAL, 0, 1'b1, -1);
        expect_done(pb);
        check_contents(0);

        // load_start pulsed mid-stream must be ignored.
        pulse_load();
        run_stream(TOTAL, 1, 1'b0, -1);
        @(posedge clk); #1;
        pb = start_pulses;
        pulse_load();
        run_stream(TOTAL, 0, 1'b0, 500);
        expect_done(pb);
        check_contents(0);

        // Reset in the middle of a load clears everything at once.
        pulse_load();
        run_stream(900, 1, 1'b0, -1);
        check_value("busy_mid_load", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_value("midrst_image", 32'(|image_flat), 32'd0);
        check_value("midrst_k1", 32'(|kernel1_flat), 32'd0);
        check_value("midrst_fcb", 32'(|fc_bias_flat), 32'd0);
        check_value("midrst_busy", 32'(busy), 32'd0);
        check_value("midrst_s_ready", 32'(s_ready), 32'd0);
        check_value("midrst_loaded", 32'(loaded), 32'd0);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
        pb = start_pulses;
        pulse_load();
        run_stream(TOTAL, 0, 1'b0, -1);
        expect_done(pb);
        check_contents(0);

`ifdef CHECKSUM_EN
        // Wrong checksum: error flag, no start pulse, back to idle.
        pb = start_pulses;
        pulse_load();
        run_stream(TOTAL, 2, 1'b0, -1);
        check_value("bad_chk_err", 32'(load_err), 32'd1);
        check_value("bad_chk_start", 32'(start_npu), 32'd0);
        check_value("bad_chk_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check_value("bad_chk_loaded", 32'(loaded), 32'd0);
        check_value("bad_chk_pulses", 32'(start_pulses - pb), 32'd0);
        check_value("bad_chk_idle_ready", 32'(s_ready), 32'd0);
        pb = start_pulses;
        pulse_load();
        check_value("err_cleared", 32'(load_err), 32'd0);
        run_stream(TOTAL, 0, 1'b0, -1);
        expect_done(pb);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
